// File: rtl/tag_alloc_pkg.sv
// Shared constants for the tag allocator slice: priority-encoder polarity
// selectors and the default pool size.
package tag_alloc_pkg;

    localparam logic ACT_HIGH      = 1'b1;
    localparam logic ACT_LOW       = 1'b0;
    localparam int   DEPTH_DEFAULT = 16;

endpackage

// File: rtl/tag_alloc_pri_enc.sv
// Lowest-index priority encoder. Reports the position of the lowest bit of
// vec equal to ACT; out is 0 when no bit matches.
module pri_enc
    import tag_alloc_pkg::*;
#(
    parameter int   IN  = DEPTH_DEFAULT,
    parameter logic ACT = ACT_HIGH,
    parameter int   W   = (IN > 1) ? $clog2(IN) : 1
) (
    input  logic [IN-1:0] vec,
    output logic          valid,
    output logic [W-1:0]  out
);

    // Scan from the top down so the last match written is the lowest index.
    always_comb begin
        valid = 1'b0;
        out   = '0;
        for (int i = IN - 1; i >= 0; i--) begin
            if (vec[i] == ACT) begin
                valid = 1'b1;
                out   = W'(i);
            end
        end
    end

endmodule

// File: rtl/tag_alloc.sv
// Free-list allocator: registered busy vector, lowest-index-free grant,
// one allocation and one release per cycle, plus a whole-pool flush.
module tag_alloc
    import tag_alloc_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int IDX   = $clog2(DEPTH),
    parameter int CNT   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_,
    input  logic             flush,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [IDX-1:0]   alloc_idx,
    input  logic             free_req,
    input  logic [IDX-1:0]   free_idx,
    output logic [DEPTH-1:0] busy,
    output logic [CNT-1:0]   count,
    output logic             full,
    output logic             empty,
    output logic             err
);

    localparam logic [IDX:0]   DEPTH_IDX = (IDX + 1)'(DEPTH);
    localparam logic [CNT-1:0] DEPTH_CNT = CNT'(DEPTH);

    logic [DEPTH-1:0] free_vec;
    logic [DEPTH-1:0] busy_nxt;
    logic [CNT-1:0]   count_nxt;
    logic             err_nxt;
    logic             grant;
    logic             free_in_range;
    logic             free_ok;

    assign free_vec = ~busy;

    pri_enc #(
        .IN  (DEPTH),
        .ACT (ACT_HIGH),
        .W   (IDX)
    ) u_pri_enc (
        .vec   (free_vec),
        .valid (alloc_valid),
        .out   (alloc_idx)
    );

    // Grant only when a slot is actually free; a legal free must hit a busy,
    // in-range slot. A legal free can never name the slot being granted,
    // because the granted slot is by construction not busy.
    always_comb begin
        grant         = alloc_req && alloc_valid;
        free_in_range = ({1'b0, free_idx} < DEPTH_IDX);
        free_ok       = free_req && free_in_range && busy[free_idx];
        busy_nxt      = busy;
        count_nxt     = count;
        err_nxt       = 1'b0;
        if (flush) begin
            busy_nxt  = '0;
            count_nxt = '0;
        end else begin
            if (grant) begin
                busy_nxt[alloc_idx] = 1'b1;
            end
            if (free_ok) begin
                busy_nxt[free_idx] = 1'b0;
            end
            unique case ({grant, free_ok})
                2'b10:   count_nxt = count + CNT'(1);
                2'b01:   count_nxt = count - CNT'(1);
                default: count_nxt = count;
            endcase
            err_nxt = free_req && !free_ok;
        end
    end

    // State registers; full/empty follow the next-state count so they always
    // agree with the busy vector they are registered alongside.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            busy  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            err   <= 1'b0;
        end else begin
            busy  <= busy_nxt;
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            empty <= (count_nxt == '0);
            err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_tag_alloc.sv
// Self-checking bench for tag_alloc: directed vector table, hand-written
// corner sequences (including a 12-slot instance) and a randomized run
// against a slot-array reference model.
module tb_tag_alloc;

    logic        clk = 1'b0;
    logic        reset_;

    logic        flush, alloc_req, free_req;
    logic [3:0]  free_idx;
    logic        alloc_valid;
    logic [3:0]  alloc_idx;
    logic [15:0] busy;
    logic [4:0]  count;
    logic        full, empty, err;

    logic        flush12, alloc_req12, free_req12;
    logic [3:0]  free_idx12;
    logic        alloc_valid12;
    logic [3:0]  alloc_idx12;
    logic [11:0] busy12;
    logic [3:0]  count12;
    logic        full12, empty12, err12;

    int n_checks = 0;
    int n_fail   = 0;

    bit mb[16];
    bit merr;

    always #5 clk = ~clk;

    tag_alloc #(.DEPTH(16)) dut (
        .clk(clk), .reset_(reset_), .flush(flush), .alloc_req(alloc_req),
        .alloc_valid(alloc_valid), .alloc_idx(alloc_idx), .free_req(free_req),
        .free_idx(free_idx), .busy(busy), .count(count), .full(full),
        .empty(empty), .err(err)
    );

    tag_alloc #(.DEPTH(12)) dut12 (
        .clk(clk), .reset_(reset_), .flush(flush12), .alloc_req(alloc_req12),
        .alloc_valid(alloc_valid12), .alloc_idx(alloc_idx12), .free_req(free_req12),
        .free_idx(free_idx12), .busy(busy12), .count(count12), .full(full12),
        .empty(empty12), .err(err12)
    );

    typedef struct {
        logic        fl;
        logic        al;
        logic        fr;
        logic [3:0]  fi;
        logic        pre_v;
        logic [3:0]  pre_i;
        logic [15:0] e_busy;
        int          e_cnt;
        logic        e_err;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model helpers: the pool is an array of slot flags.
    function automatic int model_lowest_free();
        for (int i = 0; i < 16; i++) if (!mb[i]) return i;
        return -1;
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < 16; i++) if (mb[i]) c++;
        return c;
    endfunction

    function automatic logic [15:0] model_vec();
        logic [15:0] v = '0;
        for (int i = 0; i < 16; i++) v[i] = mb[i];
        return v;
    endfunction

    task automatic model_step(input logic f, input logic a, input logic fr, input int fi);
        int  g;
        bit  legal;
        if (f) begin
            for (int i = 0; i < 16; i++) mb[i] = 1'b0;
            merr = 1'b0;
        end else begin
            g     = a ? model_lowest_free() : -1;
            legal = fr && (fi < 16) && mb[fi];
            if (legal) mb[fi] = 1'b0;
            if (g >= 0) mb[g] = 1'b1;
            merr = fr && !legal;
        end
    endtask

    task automatic drive(input logic f, input logic a, input logic fr, input logic [3:0] fi);
        @(negedge clk);
        flush = f; alloc_req = a; free_req = fr; free_idx = fi;
        #1;
    endtask

    task automatic drive12(input logic a, input logic fr, input logic [3:0] fi);
        @(negedge clk);
        flush12 = 1'b0; alloc_req12 = a; free_req12 = fr; free_idx12 = fi;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_busy"},  32'(busy),        32'h0);
        chk({tag, "_count"}, 32'(count),       32'h0);
        chk({tag, "_empty"}, 32'(empty),       32'h1);
        chk({tag, "_full"},  32'(full),        32'h0);
        chk({tag, "_err"},   32'(err),         32'h0);
        chk({tag, "_valid"}, 32'(alloc_valid), 32'h1);
        chk({tag, "_idx"},   32'(alloc_idx),   32'h0);
    endtask

    initial begin
        logic [15:0] patt;
        int          exp_i;
        logic        f, a, fr;
        logic [3:0]  fi;

        reset_ = 1'b1;
        flush = 0; alloc_req = 0; free_req = 0; free_idx = 0;
        flush12 = 0; alloc_req12 = 0; free_req12 = 0; free_idx12 = 0;
        #3 reset_ = 1'b0;
        #1 chk_zero_state("reset");
        chk("reset12_busy",  32'(busy12),  32'h0);
        chk("reset12_empty", 32'(empty12), 32'h1);
        @(posedge clk); @(posedge clk);
        @(negedge clk) reset_ = 1'b1;

        // ---------------- vector table ----------------
        for (int k = 0; k < 16; k++)
            vt.push_back(vec_t'{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, k[3:0], 16'((32'h1 << (k + 1)) - 1), k + 1, 1'b0});
        vt.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'd5,  1'b0, 4'd0, 16'hFFDF, 15, 1'b0});
        vt.push_back(vec_t'{1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 4'd5, 16'hFFFF, 16, 1'b0});
        vt.push_back(vec_t'{1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 4'd0, 16'h0000, 0,  1'b0});
        for (int k = 0; k < 8; k++)
            vt.push_back(vec_t'{1'b0, 1'b1, 1'b0, 4'd0, 1'b1, k[3:0], 16'((32'h1 << (k + 1)) - 1), k + 1, 1'b0});
        vt.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'd3,  1'b1, 4'd8, 16'h01F7, 8, 1'b0});
        vt.push_back(vec_t'{1'b0, 1'b0, 1'b1, 4'd9,  1'b1, 4'd3, 16'h01F7, 8, 1'b1});
        vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd3, 16'h01F7, 8, 1'b0});
        vt.push_back(vec_t'{1'b0, 1'b1, 1'b1, 4'd10, 1'b1, 4'd3, 16'h01FF, 9, 1'b1});
        vt.push_back(vec_t'{1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 4'd9, 16'h01FF, 9, 1'b0});

        foreach (vt[n]) begin
            drive(vt[n].fl, vt[n].al, vt[n].fr, vt[n].fi);
            chk($sformatf("vec%0d_pre_valid", n), 32'(alloc_valid), 32'(vt[n].pre_v));
            chk($sformatf("vec%0d_pre_idx", n),   32'(alloc_idx),   32'(vt[n].pre_i));
            tick();
            chk($sformatf("vec%0d_busy", n),  32'(busy),  32'(vt[n].e_busy));
            chk($sformatf("vec%0d_count", n), 32'(count), 32'(vt[n].e_cnt));
            chk($sformatf("vec%0d_full", n),  32'(full),  32'(vt[n].e_cnt == 16));
            chk($sformatf("vec%0d_empty", n), 32'(empty), 32'(vt[n].e_cnt == 0));
            chk($sformatf("vec%0d_err", n),   32'(err),   32'(vt[n].e_err));
        end

        // ---------------- flush beats alloc/free/err ----------------
        drive(1, 0, 0, 0); tick();
        for (int k = 0; k < 16; k++) begin drive(0, 1, 0, 0); tick(); end
        patt = 16'hA5A5;
        for (int k = 0; k < 16; k++) if (!patt[k]) begin drive(0, 0, 1, 4'(k)); tick(); end
        drive(0, 0, 0, 0);
        chk("a5a5_busy",  32'(busy),  32'hA5A5);
        chk("a5a5_count", 32'(count), 32'd8);
        drive(1, 1, 1, 4'd1);
        tick();
        chk("flush_busy",  32'(busy),  32'h0);
        chk("flush_count", 32'(count), 32'h0);
        chk("flush_empty", 32'(empty), 32'h1);
        chk("flush_err",   32'(err),   32'h0);

        // ---------------- 12-slot pool ----------------
        for (int k = 0; k < 12; k++) begin
            drive12(1, 0, 0);
            chk($sformatf("d12_idx%0d", k), 32'(alloc_idx12), 32'(k));
            tick();
        end
        chk("d12_full",  32'(full12),        32'h1);
        chk("d12_count", 32'(count12),       32'd12);
        chk("d12_valid", 32'(alloc_valid12), 32'h0);
        chk("d12_empty", 32'(empty12),       32'h0);
        drive12(0, 1, 4'd13); tick();
        chk("d12_oor_err",   32'(err12),   32'h1);
        chk("d12_oor_busy",  32'(busy12),  32'hFFF);
        chk("d12_oor_count", 32'(count12), 32'd12);
        drive12(0, 0, 4'd0); tick();
        chk("d12_err_clear", 32'(err12), 32'h0);
        drive12(1, 1, 4'd12); tick();
        chk("d12_oor12_err",  32'(err12),  32'h1);
        chk("d12_oor12_busy", 32'(busy12), 32'hFFF);
        drive12(0, 1, 4'd7); tick();
        chk("d12_free7_busy", 32'(busy12), 32'hF7F);
        chk("d12_free7_full", 32'(full12), 32'h0);
        drive12(0, 0, 4'd0);
        chk("d12_free7_idx",  32'(alloc_idx12), 32'd7);

        // ---------------- randomized run vs model ----------------
        drive(1, 0, 0, 0); tick();
        for (int i = 0; i < 16; i++) mb[i] = 1'b0;
        merr = 1'b0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc == 5000) begin
                drive(0, 0, 0, 0);
                #1 reset_ = 1'b0;
                #1 chk_zero_state("midreset_async");
                tick();
                chk_zero_state("midreset_held");
                @(negedge clk) reset_ = 1'b1;
                for (int i = 0; i < 16; i++) mb[i] = 1'b0;
                merr = 1'b0;
            end
            f  = ($urandom_range(0, 199) == 0);
            a  = ($urandom_range(0, 99) < 55);
            fr = ($urandom_range(0, 99) < 50);
            fi = 4'($urandom_range(0, 15));
            drive(f, a, fr, fi);
            exp_i = model_lowest_free();
            chk("rnd_valid", 32'(alloc_valid), 32'(exp_i >= 0));
            chk("rnd_idx",   32'(alloc_idx),   32'(exp_i >= 0 ? exp_i : 0));
            if (alloc_valid)
                chk("rnd_grant_not_busy", 32'(busy[alloc_idx]), 32'h0);
            model_step(f, a, fr, int'(fi));
            tick();
            chk("rnd_busy",     32'(busy),  32'(model_vec()));
            chk("rnd_count",    32'(count), 32'(model_count()));
            chk("rnd_popcount", 32'(count), 32'($countones(busy)));
            chk("rnd_full",     32'(full),  32'(model_count() == 16));
            chk("rnd_empty",    32'(empty), 32'(model_count() == 0));
            chk("rnd_err",      32'(err),   32'(merr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
